// File: rtl/mem_rd_arb.sv
// Round-robin arbiter sharing the single memory read port between pool, fc and conv.
// Owner IDs of accepted requests are queued so that in-order returns reach their client.
module mem_rd_arb #(
  parameter int NUM_REQ         = 3,
  parameter int ADDR_WIDTH      = 12,
  parameter int MAX_BYTES_TO_RD = 20,
  parameter int SIZE_W          = $clog2(MAX_BYTES_TO_RD + 1),
  parameter int MEM_DATA_BUS    = 128,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            cl_req,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] cl_addr,
  input  logic [NUM_REQ*SIZE_W-1:0]     cl_size,
  output logic [NUM_REQ-1:0]            cl_gnt,
  output logic [NUM_REQ-1:0]            cl_rd_valid,
  output logic [MEM_DATA_BUS-1:0]       cl_rd_data,
  output logic                          mem_req,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  output logic [SIZE_W-1:0]             mem_size,
  input  logic                          mem_gnt,
  input  logic                          mem_rd_valid,
  input  logic [MEM_DATA_BUS-1:0]       mem_rd_data,
  output logic                          arb_busy,
  output logic                          ret_err
);
  // state | meaning
  // IDLE  | picking a round-robin winner among cl_req
  // ISSUE | mem_req held with stable addr/size until mem_gnt
  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
  localparam logic [IDX_W:0]   NREQ_W   = (IDX_W + 1)'(NUM_REQ);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_OUTSTANDING);

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]        owner_q, owner_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [SIZE_W-1:0]       mem_size_q, mem_size_d;
  logic [IDX_W-1:0]        fifo_q [MAX_OUTSTANDING];
  logic [IDX_W-1:0]        fifo_d [MAX_OUTSTANDING];
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]        fifo_count_q, fifo_count_d;
  logic                    ret_err_q, ret_err_d;

  logic                    grant_en, found, push, pop;
  logic [IDX_W-1:0]        win, cand;
  logic [IDX_W:0]          sum;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [SIZE_W-1:0]       sel_size;

  // Search upward from rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    win      = rr_ptr_q;
    found    = 1'b0;
    sum      = '0;
    cand     = '0;
    sel_addr = '0;
    sel_size = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, rr_ptr_q} + (IDX_W + 1)'(i);
      if (sum >= NREQ_W) sum = sum - NREQ_W;
      cand = sum[IDX_W-1:0];
      if (!found && cl_req[cand]) begin
        win   = cand;
        found = 1'b1;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win == IDX_W'(i)) begin
        sel_addr = cl_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_size = cl_size[i*SIZE_W +: SIZE_W];
      end
    end
  end

  // Gated by rst so cl_gnt stays low while reset is held.
  assign grant_en = (state_q == IDLE) && found && (fifo_count_q < FULL_CNT) && !rst;
  assign push     = (state_q == ISSUE) && mem_gnt;
  assign pop      = mem_rd_valid && (fifo_count_q != '0);

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    mem_addr_d = mem_addr_q;
    mem_size_d = mem_size_q;
    cl_gnt     = '0;
    case (state_q)
      IDLE: begin
        if (grant_en) begin
          cl_gnt[win] = 1'b1;
          state_d     = ISSUE;
          owner_d     = win;
          mem_addr_d  = sel_addr;
          mem_size_d  = sel_size;
          rr_ptr_d    = (win == LAST_IDX) ? '0 : win + IDX_W'(1);
        end
      end
      ISSUE: begin
        if (mem_gnt) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    fifo_d       = fifo_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    fifo_count_d = fifo_count_q;
    cl_rd_valid  = '0;
    if (push) begin
      fifo_d[wr_ptr_q] = owner_q;
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      cl_rd_valid[fifo_q[rd_ptr_q]] = 1'b1;
      rd_ptr_d                      = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   fifo_count_d = fifo_count_q + CNT_W'(1);
      2'b01:   fifo_count_d = fifo_count_q - CNT_W'(1);
      default: fifo_count_d = fifo_count_q;
    endcase
    ret_err_d = ret_err_q | (mem_rd_valid && (fifo_count_q == '0));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      owner_q      <= '0;
      mem_addr_q   <= '0;
      mem_size_q   <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_count_q <= '0;
      ret_err_q    <= 1'b0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) fifo_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      owner_q      <= owner_d;
      mem_addr_q   <= mem_addr_d;
      mem_size_q   <= mem_size_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_count_q <= fifo_count_d;
      ret_err_q    <= ret_err_d;
      fifo_q       <= fifo_d;
    end
  end

  assign mem_req    = (state_q == ISSUE);
  assign mem_addr   = mem_addr_q;
  assign mem_size   = mem_size_q;
  assign cl_rd_data = mem_rd_data;
  assign arb_busy   = (state_q == ISSUE) || (fifo_count_q != '0);
  assign ret_err    = ret_err_q;

endmodule

// File: tb/tb_mem_rd_arb.sv
// Bench for mem_rd_arb: directed scenarios plus random traffic, checked by a
// negedge monitor against a queue-based reference model of the arbiter.
module tb_mem_rd_arb;
  localparam int NREQ = 3;
  localparam int AW   = 12;
  localparam int SW   = 5;
  localparam int DW   = 128;
  localparam int MAXO = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   cl_req;
  logic [NREQ*AW-1:0] cl_addr;
  logic [NREQ*SW-1:0] cl_size;
  logic [NREQ-1:0]   cl_gnt, cl_rd_valid;
  logic [DW-1:0]     cl_rd_data;
  logic              mem_req, mem_gnt, mem_rd_valid, arb_busy, ret_err;
  logic [AW-1:0]     mem_addr;
  logic [SW-1:0]     mem_size;
  logic [DW-1:0]     mem_rd_data;

  always #5 clk = ~clk;

  mem_rd_arb #(
    .NUM_REQ(NREQ), .ADDR_WIDTH(AW), .MAX_BYTES_TO_RD(20), .SIZE_W(SW),
    .MEM_DATA_BUS(DW), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .rst(rst), .cl_req(cl_req), .cl_addr(cl_addr), .cl_size(cl_size),
    .cl_gnt(cl_gnt), .cl_rd_valid(cl_rd_valid), .cl_rd_data(cl_rd_data),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_size(mem_size), .mem_gnt(mem_gnt),
    .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
    .arb_busy(arb_busy), .ret_err(ret_err)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: pending issue, round-robin pointer, owner queue, sticky error.
  bit            m_issue;
  int            m_rr, m_owner;
  logic [AW-1:0] m_addr;
  logic [SW-1:0] m_size;
  bit            m_err;
  int            m_out[$];
  logic [DW-1:0] exp_data_q[$];
  int            w, c;
  logic [NREQ-1:0] eg, ev;

  task automatic chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_cl_gnt", cl_gnt, 0);
      chk("rst_cl_rd_valid", cl_rd_valid, 0);
      chk("rst_mem_req", mem_req, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_size", mem_size, 0);
      chk("rst_arb_busy", arb_busy, 0);
      chk("rst_ret_err", ret_err, 0);
      m_issue = 0; m_rr = 0; m_err = 0; m_owner = 0;
      m_out.delete();
      exp_data_q.delete();
    end else begin
      eg = '0;
      w  = -1;
      if (!m_issue && cl_req != '0 && m_out.size() < MAXO)
        for (int k = 0; k < NREQ; k++) begin
          c = (m_rr + k) % NREQ;
          if (w < 0 && cl_req[c]) w = c;
        end
      if (w >= 0) eg[w] = 1'b1;
      chk("cl_gnt", cl_gnt, eg);
      chk("mem_req", mem_req, m_issue);
      if (m_issue) begin
        chk("mem_addr", mem_addr, m_addr);
        chk("mem_size", mem_size, m_size);
      end
      chk("arb_busy", arb_busy, m_issue || m_out.size() != 0);
      chk("ret_err", ret_err, m_err);
      ev = '0;
      if (mem_rd_valid && m_out.size() != 0) ev[m_out[0]] = 1'b1;
      chk("cl_rd_valid", cl_rd_valid, ev);
      if (mem_rd_valid && exp_data_q.size() != 0)
        chk("cl_rd_data", cl_rd_data, exp_data_q.pop_front());
      if (mem_rd_valid) begin
        if (m_out.size() != 0) void'(m_out.pop_front());
        else m_err = 1;
      end
      if (m_issue && mem_gnt) begin
        m_out.push_back(m_owner);
        m_issue = 0;
      end else if (w >= 0) begin
        m_issue = 1;
        m_owner = w;
        m_addr  = cl_addr[w*AW +: AW];
        m_size  = cl_size[w*SW +: SW];
        m_rr    = (w + 1) % NREQ;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cl(int ci, logic [AW-1:0] a, logic [SW-1:0] s);
    cl_addr[ci*AW +: AW] = a;
    cl_size[ci*SW +: SW] = s;
  endtask

  task automatic ret();
    mem_rd_data  = {$urandom, $urandom, $urandom, $urandom};
    mem_rd_valid = 1'b1;
    exp_data_q.push_back(mem_rd_data);
    step();
    mem_rd_valid = 1'b0;
  endtask

  // One-cycle request from an idle arbiter; the second cycle is the ISSUE cycle.
  task automatic req1(int ci);
    cl_req = '0;
    cl_req[ci] = 1'b1;
    step();
    cl_req = '0;
    step();
  endtask

  task automatic drain();
    for (int k = 0; k < 8 && m_out.size() != 0; k++) ret();
  endtask

  initial begin
    rst = 1'b1;
    cl_req = '0; cl_addr = '0; cl_size = '0;
    mem_gnt = 1'b0; mem_rd_valid = 1'b0; mem_rd_data = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    step();

    // single request
    set_cl(0, 12'h123, 5'd20);
    mem_gnt = 1'b1;
    req1(0);
    mem_gnt = 1'b0;
    step();
    ret();
    step();

    // round robin with all clients requesting
    for (int i = 0; i < NREQ; i++) set_cl(i, AW'(12'h100 + i), SW'(i + 1));
    mem_gnt = 1'b1;
    cl_req = '1;
    repeat (8) step();
    cl_req = '0;
    step();
    drain();

    // memory stall
    set_cl(2, 12'hABC, 5'd7);
    mem_gnt = 1'b0;
    cl_req = 3'b100;
    step();
    cl_req = '0;
    repeat (5) step();
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    step();
    drain();

    // outstanding limit with owners 0,2,1,0
    mem_gnt = 1'b1;
    req1(0); req1(2); req1(1); req1(0);
    cl_req = 3'b010;
    repeat (3) step();
    ret();
    step();
    cl_req = '0;
    step();
    repeat (6) step();
    drain();
    step();

    // stray return
    ret();
    repeat (3) step();

    // reset while in ISSUE with two outstanding
    mem_gnt = 1'b1;
    req1(1); req1(2);
    mem_gnt = 1'b0;
    cl_req = 3'b001;
    step();
    cl_req = '0;
    rst = 1'b1;
    #1;
    chk("mid_rst_cl_gnt", cl_gnt, 0);
    chk("mid_rst_mem_req", mem_req, 0);
    chk("mid_rst_mem_addr", mem_addr, 0);
    chk("mid_rst_mem_size", mem_size, 0);
    chk("mid_rst_arb_busy", arb_busy, 0);
    chk("mid_rst_ret_err", ret_err, 0);
    chk("mid_rst_cl_rd_valid", cl_rd_valid, 0);
    step();
    step();
    rst = 1'b0;
    step();
    ret();
    step();
    chk("post_rst_ret_err", ret_err, 1);

    // reset again, then random traffic
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    for (int k = 0; k < 1500; k++) begin
      cl_req = NREQ'($urandom_range(0, 7));
      for (int i = 0; i < NREQ; i++) set_cl(i, AW'($urandom), SW'($urandom_range(0, 20)));
      mem_gnt = ($urandom_range(0, 2) != 0);
      if ((m_out.size() != 0 && $urandom_range(0, 1) == 1) || $urandom_range(0, 299) == 0) begin
        mem_rd_data  = {$urandom, $urandom, $urandom, $urandom};
        mem_rd_valid = 1'b1;
        exp_data_q.push_back(mem_rd_data);
      end else begin
        mem_rd_valid = 1'b0;
      end
      step();
    end
    cl_req = '0;
    mem_rd_valid = 1'b0;
    mem_gnt = 1'b1;
    repeat (3) step();
    drain();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
